axi_arp_rx_wide: RTL and testbench
==================================

AXI_ARP_RX_WIDE -- requirements
Module: axi_arp_rx_wide

Interface
REQ-001 Parameter DEBUG, default 1, SHALL enable the $display of each record written to the FIFO.
REQ-002 Parameter DATA_BYTES, default 1, SHALL set the stream width in bytes; legal values are 1, 2, 4 and 8.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the record queue depth; legal values are powers of 2 from 2 to 16.
REQ-004 Parameter FILTER_EN, default 1, SHALL enable target-IP filtering.
REQ-005 Parameter LOCAL_IP, default 32'hc0a80602, SHALL be the local IPv4 address used by the filter.
REQ-006 Port clk, input, 1 bit, SHALL be the single clock; every register samples on its rising edge.
REQ-007 Port areset, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-008 Ports s_axis_tvalid, s_axis_tlast (input, 1 bit) and s_axis_tready (output, 1 bit) SHALL be the AXI-Stream ARP payload handshake; the stream carries no Ethernet header.
REQ-009 Port s_axis_tdata, input, 8*DATA_BYTES bits, SHALL carry payload bytes; lane 0 = bits [7:0] = earliest byte.
REQ-010 Port s_axis_tkeep, input, DATA_BYTES bits, SHALL mark valid lanes: contiguous from lane 0, all ones on every beat except the tlast beat.
REQ-011 Ports arp_valid (output, 1) and arp_ready (input, 1) SHALL form the record output handshake.
REQ-012 Outputs arp_opcode (16), arp_src_mac (48), arp_src_ip (32), arp_dst_mac (48) and arp_dst_ip (32) SHALL carry the record at the head of the FIFO.
REQ-013 Outputs cnt_good, cnt_malformed, cnt_filtered and cnt_overflow, 16 bits each, SHALL be saturating frame statistics.

Function
REQ-014 The block SHALL keep a byte index that starts at 0 on each frame and advances by popcount(tkeep) on each accepted beat; lane k of a beat holds byte index+k.
REQ-015 Bytes 0-27 SHALL be decoded by absolute index as follows:
- htype = 0x0001
- ptype = 0x0800
- hlen = 6
- plen = 4
- opcode = bytes 6-7, big-endian
- sha = bytes 8-13
- spa = bytes 14-17
- tha = bytes 18-23
- tpa = bytes 24-27
REQ-016 A frame SHALL be marked malformed if any of the following is true: a fixed field (htype, ptype, hlen, plen) mismatches; opcode is neither 1 nor 2; tlast arrives before byte 27.
REQ-017 Bytes beyond index 27 (Ethernet padding) SHALL be accepted and discarded without error.
REQ-018 The state machine SHALL have three states: S_HDR (decoding bytes 0-27), S_PAD (bytes after 27 until tlast) and S_DROP (malformed, until tlast).
- S_HDR moves to S_PAD once byte 27 is accepted without tlast.
- S_HDR moves to S_DROP on a mismatch without tlast.
- Any accepted tlast returns the machine to S_HDR with index 0.
REQ-019 On the tlast beat of a frame that is not malformed, the block SHALL take exactly one of these actions, in this priority order:
- FILTER_EN=1 and tpa != LOCAL_IP: increment cnt_filtered.
- FIFO full and no pop this cycle: increment cnt_overflow and drop the record.
- Otherwise: push the record and increment cnt_good.
REQ-020 On the tlast beat of a malformed frame, the block SHALL increment cnt_malformed only.
REQ-021 Each counter SHALL saturate at 16'hffff.
REQ-022 s_axis_tready SHALL be 1 in every cycle after reset; frames are never back-pressured, and overflow is handled by dropping per REQ-019.
REQ-023 A record SHALL appear on the outputs with arp_valid=1 one cycle after its tlast beat when the FIFO was empty (latency 1).
REQ-024 The FIFO SHALL pop when arp_valid and arp_ready are both 1.
REQ-025 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-026 Output fields SHALL remain stable while arp_valid=1 and arp_ready=0.
REQ-027 Records SHALL leave the FIFO in arrival order.

Reset
REQ-028 While areset=1 at a clock edge, the block SHALL hold these values:
- state = S_HDR, index = 0
- FIFO empty, so arp_valid = 0
- every counter = 0
- s_axis_tready = 0
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; the first beat after reset releases is byte 0 of a new frame.
REQ-030 Record data fields SHALL be don't-care while arp_valid=0.

Structure
REQ-031 ARP_HW_TYPE, ARP_PROTO_TYPE, ARP_HW_SIZE, ARP_PROTO_SIZE, the opcode constants and the packed struct arp_rec_t (opcode, sha, spa, tha, tpa) SHALL reside in the shared axi_udp_pkg.
REQ-032 The record queue SHALL be a sub-module arp_rec_fifo, parameterised by DEPTH and the arp_rec_t width, with first-word fall-through output.
REQ-033 The parser SHALL use the existing two-process style: a combinational next-state block plus one clocked register update.

Verification
REQ-034 Scenario, DATA_BYTES=4: a valid 28-byte request to 192.168.6.2 followed by 18 bytes of padding (tlast on byte 45, tkeep=4'b0011) -> one record with opcode 1 and correct sha/spa/tha/tpa; cnt_good=1.
REQ-035 Scenario: a frame with ptype 0x86DD -> no record; cnt_malformed=1; the next valid frame is parsed correctly.
REQ-036 Scenario: a 20-byte runt frame, then a valid frame -> cnt_malformed=1, then one good record.
REQ-037 Scenario, FILTER_EN=1: tpa=192.168.6.9 -> cnt_filtered=1; arp_valid stays 0.
REQ-038 Scenario, FIFO_DEPTH=2, arp_ready=0: three valid frames -> the first two are queued, cnt_overflow=1; then raise arp_ready -> two records are popped in order.
REQ-039 Scenario: assert areset for 1 cycle in the middle of a frame, then send a valid frame -> counters=0 and exactly one good record.

Source files
------------

// File: rtl/axi_udp_pkg.sv
// Shared ARP/UDP definitions: fixed ARP header constants, record layout and helpers.
package axi_udp_pkg;

   localparam logic [15:0] ARP_HW_TYPE    = 16'h0001;
   localparam logic [15:0] ARP_PROTO_TYPE = 16'h0800;
   localparam logic [7:0]  ARP_HW_SIZE    = 8'd6;
   localparam logic [7:0]  ARP_PROTO_SIZE = 8'd4;
   localparam logic [15:0] ARP_OP_REQUEST = 16'd1;
   localparam logic [15:0] ARP_OP_REPLY   = 16'd2;
   localparam int          ARP_HDR_LEN    = 28;

   typedef struct packed {
      logic [15:0] opcode;
      logic [47:0] sha;
      logic [31:0] spa;
      logic [47:0] tha;
      logic [31:0] tpa;
   } arp_rec_t;

   typedef enum logic [1:0] {S_HDR, S_PAD, S_DROP} arp_state_t;

   // Expected value of the fixed bytes 0..5 (htype, ptype, hlen, plen).
   function automatic logic [7:0] arp_fixed_byte(input int i);
      case (i)
         0:       return ARP_HW_TYPE[15:8];
         1:       return ARP_HW_TYPE[7:0];
         2:       return ARP_PROTO_TYPE[15:8];
         3:       return ARP_PROTO_TYPE[7:0];
         4:       return ARP_HW_SIZE;
         5:       return ARP_PROTO_SIZE;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hffff) ? c : c + 16'd1;
   endfunction

endpackage

// File: rtl/arp_rec_fifo.sv
// First-word fall-through record queue; push and pop in the same cycle both succeed, even when full.
module arp_rec_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 176
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             empty, do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign valid   = !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop && !empty;
   // When full, the slot being written is the one popped at this same edge.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/axi_arp_rx_wide.sv
// ARP payload parser on a multi-byte AXI-Stream: decodes the 28-byte header, validates it,
// optionally filters on target IP and queues records with saturating frame statistics.
module axi_arp_rx_wide
   import axi_udp_pkg::*;
#(
   parameter int          DEBUG      = 1,
   parameter int          DATA_BYTES = 1,
   parameter int          FIFO_DEPTH = 4,
   parameter int          FILTER_EN  = 1,
   parameter logic [31:0] LOCAL_IP   = 32'hc0a80602
) (
   input  logic                    clk,
   input  logic                    areset,
   input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
   input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic                    arp_valid,
   input  logic                    arp_ready,
   output logic [15:0]             arp_opcode,
   output logic [47:0]             arp_src_mac,
   output logic [31:0]             arp_src_ip,
   output logic [47:0]             arp_dst_mac,
   output logic [31:0]             arp_dst_ip,
   output logic [15:0]             cnt_good,
   output logic [15:0]             cnt_malformed,
   output logic [15:0]             cnt_filtered,
   output logic [15:0]             cnt_overflow
);

   arp_state_t state, state_n;
   logic [5:0] idx, idx_n;
   arp_rec_t   rec, rec_n, head;
   logic [3:0] nbytes;
   logic       beat, mism, end_good, end_bad;
   logic       filt, ovf, fifo_full, fifo_push, fifo_pop;
   int         bi;
   logic [7:0] bv;

   assign beat = s_axis_tvalid && s_axis_tready;

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      rec_n    = rec;
      mism     = 1'b0;
      end_good = 1'b0;
      end_bad  = 1'b0;
      bi       = 0;
      bv       = '0;
      nbytes   = '0;
      for (int k = 0; k < DATA_BYTES; k++)
         if (s_axis_tkeep[k]) nbytes = nbytes + 4'd1;
      if (beat) begin
         case (state)
            S_HDR: begin
               // Lanes are decoded in order so byte 7 sees the opcode high byte from this beat.
               for (int k = 0; k < DATA_BYTES; k++) begin
                  bi = int'(idx) + k;
                  bv = s_axis_tdata[8*k +: 8];
                  if (s_axis_tkeep[k]) begin
                     if (bi <= 5) begin
                        if (bv != arp_fixed_byte(bi)) mism = 1'b1;
                     end else if (bi == 6) begin
                        rec_n.opcode[15:8] = bv;
                     end else if (bi == 7) begin
                        rec_n.opcode[7:0] = bv;
                        if (rec_n.opcode != ARP_OP_REQUEST && rec_n.opcode != ARP_OP_REPLY)
                           mism = 1'b1;
                     end else if (bi <= 13) begin
                        rec_n.sha[8*(13-bi) +: 8] = bv;
                     end else if (bi <= 17) begin
                        rec_n.spa[8*(17-bi) +: 8] = bv;
                     end else if (bi <= 23) begin
                        rec_n.tha[8*(23-bi) +: 8] = bv;
                     end else if (bi <= 27) begin
                        rec_n.tpa[8*(27-bi) +: 8] = bv;
                     end
                  end
               end
               if (s_axis_tlast) begin
                  state_n = S_HDR;
                  idx_n   = '0;
                  if (mism || (int'(idx) + int'(nbytes) < ARP_HDR_LEN)) end_bad = 1'b1;
                  else end_good = 1'b1;
               end else if (mism) begin
                  state_n = S_DROP;
                  idx_n   = '0;
               end else if (int'(idx) + int'(nbytes) >= ARP_HDR_LEN) begin
                  state_n = S_PAD;
                  idx_n   = '0;
               end else begin
                  idx_n = idx + 6'(nbytes);
               end
            end
            S_PAD: begin
               if (s_axis_tlast) begin
                  state_n  = S_HDR;
                  end_good = 1'b1;
               end
            end
            S_DROP: begin
               if (s_axis_tlast) begin
                  state_n = S_HDR;
                  end_bad = 1'b1;
               end
            end
            default: state_n = S_HDR;
         endcase
      end
   end

   // Filtering outranks overflow, so a filtered frame never counts as dropped.
   assign fifo_pop  = arp_valid && arp_ready;
   assign filt      = (FILTER_EN != 0) && (rec_n.tpa != LOCAL_IP);
   assign fifo_push = end_good && !filt && (!fifo_full || fifo_pop);
   assign ovf       = end_good && !filt && fifo_full && !fifo_pop;

   always_ff @(posedge clk) begin
      if (areset) begin
         state         <= S_HDR;
         idx           <= '0;
         s_axis_tready <= 1'b0;
         cnt_good      <= '0;
         cnt_malformed <= '0;
         cnt_filtered  <= '0;
         cnt_overflow  <= '0;
      end else begin
         state         <= state_n;
         idx           <= idx_n;
         rec           <= rec_n;
         s_axis_tready <= 1'b1;
         if (fifo_push)         cnt_good      <= sat_inc(cnt_good);
         if (end_bad)           cnt_malformed <= sat_inc(cnt_malformed);
         if (end_good && filt)  cnt_filtered  <= sat_inc(cnt_filtered);
         if (ovf)               cnt_overflow  <= sat_inc(cnt_overflow);
      end
   end

   arp_rec_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(arp_rec_t))
   ) u_fifo (
      .clk    (clk),
      .areset (areset),
      .push   (fifo_push),
      .din    (rec_n),
      .pop    (fifo_pop),
      .dout   (head),
      .valid  (arp_valid),
      .full   (fifo_full)
   );

   assign arp_opcode  = head.opcode;
   assign arp_src_mac = head.sha;
   assign arp_src_ip  = head.spa;
   assign arp_dst_mac = head.tha;
   assign arp_dst_ip  = head.tpa;

   if (DEBUG != 0) begin : g_debug
      always_ff @(posedge clk) begin
         if (!areset && fifo_push)
            $display("arp rec: op=%h sha=%h spa=%h tha=%h tpa=%h",
                     rec_n.opcode, rec_n.sha, rec_n.spa, rec_n.tha, rec_n.tpa);
      end
   end

endmodule

// File: tb/tb_axi_arp_rx_wide.sv
// Bench for axi_arp_rx_wide: table of frame kinds, hand sequences for overflow/reset, random traffic vs a queue model.
module tb_axi_arp_rx_wide;

   localparam int          DB    = 4;
   localparam int          DEPTH = 2;
   localparam logic [31:0] LIP   = 32'hc0a80602;
   localparam int O_NONE = 0, O_GOOD = 1, O_MAL = 2, O_FILT = 3;
   localparam int K_GOOD = 0, K_REPLY = 1, K_PTYPE = 2, K_FILT = 3, K_BADOP = 4, K_HLEN = 5;

   logic            clk = 1'b0;
   logic            areset = 1'b1;
   logic [8*DB-1:0] s_axis_tdata = '0;
   logic [DB-1:0]   s_axis_tkeep = '0;
   logic            s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
   logic            arp_valid, arp_ready = 1'b0;
   logic [15:0]     arp_opcode;
   logic [47:0]     arp_src_mac, arp_dst_mac;
   logic [31:0]     arp_src_ip, arp_dst_ip;
   logic [15:0]     cnt_good, cnt_malformed, cnt_filtered, cnt_overflow;

   always #5 clk = ~clk;

   axi_arp_rx_wide #(
      .DEBUG(0), .DATA_BYTES(DB), .FIFO_DEPTH(DEPTH), .FILTER_EN(1), .LOCAL_IP(LIP)
   ) dut (
      .clk(clk), .areset(areset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .arp_valid(arp_valid), .arp_ready(arp_ready),
      .arp_opcode(arp_opcode), .arp_src_mac(arp_src_mac), .arp_src_ip(arp_src_ip),
      .arp_dst_mac(arp_dst_mac), .arp_dst_ip(arp_dst_ip),
      .cnt_good(cnt_good), .cnt_malformed(cnt_malformed),
      .cnt_filtered(cnt_filtered), .cnt_overflow(cnt_overflow)
   );

   int total = 0, bad = 0;
   logic [7:0]   fr[$];
   logic [175:0] mq[$];
   logic [175:0] cur_rec, rec_a, rec_b;
   int m_good, m_mal, m_filt, m_ovf;

   typedef struct {
      int          kind;
      int          len;
      logic [15:0] eg, em, ef;
   } vec_t;
   vec_t vt[10];

   task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic [175:0] out_rec();
      return {arp_opcode, arp_src_mac, arp_src_ip, arp_dst_mac, arp_dst_ip};
   endfunction

   task automatic build(input logic [15:0] op, input logic [15:0] ptype, input logic [7:0] hlen,
                        input logic [31:0] tpa, input int len);
      fr.delete();
      fr.push_back(8'h00); fr.push_back(8'h01);
      fr.push_back(ptype[15:8]); fr.push_back(ptype[7:0]);
      fr.push_back(hlen); fr.push_back(8'h04);
      fr.push_back(op[15:8]); fr.push_back(op[7:0]);
      for (int i = 0; i < 16; i++) fr.push_back(8'($urandom));
      for (int i = 3; i >= 0; i--) fr.push_back(tpa[8*i +: 8]);
      while (fr.size() < len) fr.push_back(8'($urandom));
      while (fr.size() > len) void'(fr.pop_back());
   endtask

   task automatic build_kind(input int kind, input int len);
      case (kind)
         K_GOOD:  build(16'd1, 16'h0800, 8'd6, LIP, len);
         K_REPLY: build(16'd2, 16'h0800, 8'd6, LIP, len);
         K_PTYPE: build(16'd1, 16'h86dd, 8'd6, LIP, len);
         K_FILT:  build(16'd1, 16'h0800, 8'd6, 32'hc0a80609, len);
         K_BADOP: build(16'd3, 16'h0800, 8'd6, LIP, len);
         default: build(16'd1, 16'h0800, 8'd5, LIP, len);
      endcase
   endtask

   // Outcome of a whole frame, straight from the ARP rules (overflow decided at push time).
   function automatic int classify();
      logic [15:0] op;
      logic [31:0] tpa;
      if (fr.size() < 28) return O_MAL;
      if (fr[0] != 8'h00 || fr[1] != 8'h01 || fr[2] != 8'h08 || fr[3] != 8'h00 ||
          fr[4] != 8'h06 || fr[5] != 8'h04) return O_MAL;
      op = {fr[6], fr[7]};
      if (op != 16'd1 && op != 16'd2) return O_MAL;
      tpa = {fr[24], fr[25], fr[26], fr[27]};
      if (tpa != LIP) return O_FILT;
      return O_GOOD;
   endfunction

   function automatic logic [175:0] mkrec();
      logic [175:0] r = '0;
      if (fr.size() >= 28)
         for (int i = 6; i < 28; i++) r = {r[167:0], fr[i]};
      return r;
   endfunction

   function automatic bit rdy_of(input int rmode);
      if (rmode == 0) return 1'b0;
      if (rmode == 1) return 1'b1;
      return 1'($urandom_range(1));
   endfunction

   task automatic check_cycle();
      chk("tready", s_axis_tready, 1);
      chk("arp_valid", arp_valid, mq.size() > 0);
      if (mq.size() > 0) chk("record", out_rec(), mq[0]);
      chk("cnt_good", cnt_good, m_good);
      chk("cnt_malformed", cnt_malformed, m_mal);
      chk("cnt_filtered", cnt_filtered, m_filt);
      chk("cnt_overflow", cnt_overflow, m_ovf);
   endtask

   task automatic tick(input bit v, input bit last, input logic [8*DB-1:0] d, input logic [DB-1:0] k,
                       input bit rdy, input int outc);
      bit pop, push;
      s_axis_tvalid = v; s_axis_tlast = last; s_axis_tdata = d; s_axis_tkeep = k;
      arp_ready = rdy;
      pop  = (mq.size() > 0) && rdy;
      push = 1'b0;
      @(posedge clk);
      case (outc)
         O_GOOD: if (mq.size() == DEPTH && !pop) m_ovf++; else begin push = 1'b1; m_good++; end
         O_MAL:  m_mal++;
         O_FILT: m_filt++;
         default: ;
      endcase
      if (pop)  mq.delete(0);
      if (push) mq.push_back(cur_rec);
      #1;
      check_cycle();
   endtask

   // cut>0 sends only that many beats and no tlast.
   task automatic send_frame(input int rmode, input int cut);
      int n, nb, o;
      bit lst;
      logic [8*DB-1:0] d;
      logic [DB-1:0] kp;
      n  = fr.size();
      nb = (n + DB - 1) / DB;
      if (cut > 0 && cut < nb) nb = cut;
      o  = classify();
      cur_rec = mkrec();
      for (int b = 0; b < nb; b++) begin
         if (rmode == 2)
            while ($urandom_range(3) == 0) tick(1'b0, 1'b0, 32'($urandom), '0, rdy_of(rmode), O_NONE);
         d  = 32'($urandom);
         kp = '0;
         for (int j = 0; j < DB; j++)
            if (b*DB + j < n) begin
               d[8*j +: 8] = fr[b*DB + j];
               kp[j] = 1'b1;
            end
         lst = (b == nb - 1) && (cut == 0);
         tick(1'b1, lst, d, kp, rdy_of(rmode), lst ? o : O_NONE);
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic do_reset();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      areset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_valid", arp_valid, 0);
      chk("rst_counters", {cnt_good, cnt_malformed, cnt_filtered, cnt_overflow}, 0);
      areset = 1'b0;
      mq.delete();
      m_good = 0; m_mal = 0; m_filt = 0; m_ovf = 0;
      tick(1'b0, 1'b0, '0, '0, 1'b1, O_NONE);
   endtask

   initial begin
      vt[0] = '{K_GOOD,  46, 16'd1, 16'd0, 16'd0};
      vt[1] = '{K_PTYPE, 28, 16'd1, 16'd1, 16'd0};
      vt[2] = '{K_REPLY, 28, 16'd2, 16'd1, 16'd0};
      vt[3] = '{K_GOOD,  20, 16'd2, 16'd2, 16'd0};
      vt[4] = '{K_GOOD,  60, 16'd3, 16'd2, 16'd0};
      vt[5] = '{K_FILT,  28, 16'd3, 16'd2, 16'd1};
      vt[6] = '{K_BADOP, 32, 16'd3, 16'd3, 16'd1};
      vt[7] = '{K_HLEN,  28, 16'd3, 16'd4, 16'd1};
      vt[8] = '{K_GOOD,  27, 16'd3, 16'd5, 16'd1};
      vt[9] = '{K_GOOD,  29, 16'd4, 16'd5, 16'd1};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         build_kind(vt[i].kind, vt[i].len);
         send_frame(1, 0);
         tick(1'b0, 1'b0, '0, '0, 1'b1, O_NONE);
         chk($sformatf("tbl%0d_good", i), cnt_good, vt[i].eg);
         chk($sformatf("tbl%0d_malformed", i), cnt_malformed, vt[i].em);
         chk($sformatf("tbl%0d_filtered", i), cnt_filtered, vt[i].ef);
         chk($sformatf("tbl%0d_valid", i), arp_valid, 0);
      end

      // Overflow with a 2-deep queue and a stalled consumer.
      do_reset();
      build_kind(K_GOOD, 28); rec_a = mkrec(); send_frame(0, 0);
      build_kind(K_REPLY, 40); rec_b = mkrec(); send_frame(0, 0);
      build_kind(K_GOOD, 30); send_frame(0, 0);
      tick(1'b0, 1'b0, '0, '0, 1'b0, O_NONE);
      chk("ovf_count", cnt_overflow, 16'd1);
      chk("ovf_good", cnt_good, 16'd2);
      chk("ovf_head_a", out_rec(), rec_a);
      tick(1'b0, 1'b0, '0, '0, 1'b1, O_NONE);
      chk("ovf_head_b", out_rec(), rec_b);
      chk("ovf_valid_b", arp_valid, 1);
      tick(1'b0, 1'b0, '0, '0, 1'b1, O_NONE);
      chk("ovf_drained", arp_valid, 0);

      // Reset in the middle of a frame, then a clean frame.
      build_kind(K_GOOD, 28); send_frame(1, 0);
      build_kind(K_GOOD, 46); send_frame(1, 3);
      do_reset();
      build_kind(K_GOOD, 28); rec_a = mkrec(); send_frame(0, 0);
      tick(1'b0, 1'b0, '0, '0, 1'b0, O_NONE);
      chk("rstmid_good", cnt_good, 16'd1);
      chk("rstmid_malformed", cnt_malformed, 16'd0);
      chk("rstmid_rec", out_rec(), rec_a);
      tick(1'b0, 1'b0, '0, '0, 1'b1, O_NONE);

      // Random traffic with random consumer stalls.
      do_reset();
      for (int i = 0; i < 60; i++) begin
         build_kind(($urandom_range(9) < 5) ? K_GOOD : int'($urandom_range(5, 1)),
                    int'($urandom_range(60, 18)));
         send_frame(2, 0);
      end
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0, '0, 1'b1, O_NONE);
      chk("rand_drained", arp_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
